// File: rtl/matmul_seq_if.sv
// Operand-load, start/status and result-read signals of matmul_seq.
interface matmul_seq_if #(
    parameter int N  = 3,
    parameter int DW = 8,
    parameter int RW = 2*DW + $clog2(N)
);
    localparam int AW = $clog2(N*N);

    logic          load_en;
    logic          load_sel;
    logic [AW-1:0] load_addr;
    logic [DW-1:0] load_data;
    logic          start;
    logic          busy;
    logic          done;
    logic [AW-1:0] rd_addr;
    logic [RW-1:0] rd_data;

    modport master (
        output load_en, load_sel, load_addr, load_data, start, rd_addr,
        input  busy, done, rd_data
    );

    modport slave (
        input  load_en, load_sel, load_addr, load_data, start, rd_addr,
        output busy, done, rd_data
    );
endinterface

// File: rtl/matmul_seq.sv
// Sequential NxN matrix multiplier with a single MAC and A/B/C register files.
// Define MATMUL_SIGNED_EN for two's-complement operands and results.
module matmul_seq #(
    parameter int N  = 3,
    parameter int DW = 8,
    parameter int RW = 2*DW + $clog2(N)
) (
    input  logic       clk,
    input  logic       rst,
    matmul_seq_if.slave bus
);
    localparam int NN = N*N;
    localparam int AW = $clog2(NN);
    localparam int CW = $clog2(N);
    localparam logic [CW-1:0] LAST = CW'(N-1);
    localparam logic [AW:0]   NN_L = (AW+1)'(NN);

    typedef enum logic [1:0] {IDLE, MAC, WRITE, DONE} state_t;

    state_t        state, state_nxt;
    logic [CW-1:0] i, j, k;
    logic [RW-1:0] acc;
    logic [DW-1:0] a_mem [NN];
    logic [DW-1:0] b_mem [NN];
    logic [RW-1:0] c_mem [NN];
    logic [AW-1:0] a_idx, b_idx, c_idx;
    logic [RW-1:0] prod_ext;
    logic          load_ok, rd_ok;

    always_comb begin
        a_idx   = AW'(int'(i) * N + int'(k));
        b_idx   = AW'(int'(k) * N + int'(j));
        c_idx   = AW'(int'(i) * N + int'(j));
        load_ok = {1'b0, bus.load_addr} < NN_L;
        rd_ok   = {1'b0, bus.rd_addr} < NN_L;
    end

`ifdef MATMUL_SIGNED_EN
    logic signed [2*DW-1:0] prod;
    // Signed size cast sign-extends the product up to RW.
    always_comb begin
        prod     = $signed(a_mem[a_idx]) * $signed(b_mem[b_idx]);
        prod_ext = RW'(prod);
    end
`else
    logic [2*DW-1:0] prod;
    always_comb begin
        prod     = a_mem[a_idx] * b_mem[b_idx];
        prod_ext = RW'(prod);
    end
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (bus.start) state_nxt = MAC;
            MAC:     if (k == LAST) state_nxt = WRITE;
            WRITE:   state_nxt = (i == LAST && j == LAST) ? DONE : MAC;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        bus.busy = (state == MAC) || (state == WRITE);
        bus.done = (state == DONE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            i           <= '0;
            j           <= '0;
            k           <= '0;
            acc         <= '0;
            bus.rd_data <= '0;
            for (int unsigned e = 0; e < NN; e++) begin
                a_mem[e] <= '0;
                b_mem[e] <= '0;
                c_mem[e] <= '0;
            end
        end else begin
            bus.rd_data <= rd_ok ? c_mem[bus.rd_addr] : '0;
            case (state)
                IDLE: begin
                    if (bus.load_en && load_ok) begin
                        if (bus.load_sel) b_mem[bus.load_addr] <= bus.load_data;
                        else              a_mem[bus.load_addr] <= bus.load_data;
                    end
                    if (bus.start) begin
                        i   <= '0;
                        j   <= '0;
                        k   <= '0;
                        acc <= '0;
                    end
                end
                MAC: begin
                    acc <= acc + prod_ext;
                    if (k != LAST) k <= k + 1'b1;
                end
                WRITE: begin
                    c_mem[c_idx] <= acc;
                    acc          <= '0;
                    k            <= '0;
                    if (j == LAST) begin
                        j <= '0;
                        i <= (i == LAST) ? '0 : i + 1'b1;
                    end else begin
                        j <= j + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_matmul_seq.sv
// Scoreboard bench for matmul_seq: expected C pushed at start, popped on readback.
module tb_matmul_seq;
    localparam int N  = 3;
    localparam int DW = 8;
    localparam int RW = 2*DW + $clog2(N);
    localparam int NN = N*N;
    localparam int AW = $clog2(NN);
    localparam int RUN_CYCLES = NN * (N + 1);

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    matmul_seq_if #(.N(N), .DW(DW), .RW(RW)) bus ();
    matmul_seq #(.N(N), .DW(DW), .RW(RW)) dut (.clk(clk), .rst(rst), .bus(bus.slave));

    int total = 0;
    int bad   = 0;
    logic [DW-1:0] ma [NN];
    logic [DW-1:0] mb [NN];
    logic [RW-1:0] sb [$];

    function automatic logic [RW-1:0] model_c(int r, int c);
        longint s = 0;
        for (int t = 0; t < N; t++) begin
`ifdef MATMUL_SIGNED_EN
            s += longint'(byte'(ma[r*N+t])) * longint'(byte'(mb[t*N+c]));
`else
            s += longint'(ma[r*N+t]) * longint'(mb[t*N+c]);
`endif
        end
        return RW'(s);
    endfunction

    task automatic push_expected();
        for (int e = 0; e < NN; e++) sb.push_back(model_c(e / N, e % N));
    endtask

    task automatic idle_inputs();
        bus.load_en = 0; bus.load_sel = 0; bus.load_addr = '0; bus.load_data = '0;
        bus.start = 0; bus.rd_addr = '0;
    endtask

    task automatic clear_model();
        for (int e = 0; e < NN; e++) begin ma[e] = '0; mb[e] = '0; end
    endtask

    task automatic load(input logic sel, input int addr, input logic [DW-1:0] d);
        bus.load_en = 1; bus.load_sel = sel; bus.load_addr = AW'(addr); bus.load_data = d;
        if (addr < NN) begin
            if (sel) mb[addr] = d;
            else     ma[addr] = d;
        end
        @(negedge clk);
        bus.load_en = 0;
    endtask

    task automatic read_c(input int addr, output logic [RW-1:0] v);
        bus.rd_addr = AW'(addr);
        @(negedge clk);
        v = bus.rd_data;
    endtask

    // Pulses start (model snapshot taken at the same moment), then follows busy/done.
    // With inject set, a load of A[0]=99 and a second start arrive mid-run.
    task automatic run(input bit inject, output int busy_cnt, output int done_cnt, output int overlap);
        bit fin = 0;
        bus.start = 1;
        push_expected();
        @(negedge clk);
        bus.start = 0;
        busy_cnt = 0; done_cnt = 0; overlap = 0;
        for (int cyc = 0; cyc < 2000 && !fin; cyc++) begin
            if (bus.busy && bus.done) overlap++;
            if (bus.busy) busy_cnt++;
            if (bus.done) begin done_cnt++; fin = 1; end
            if (inject && cyc == 5) begin
                bus.load_en = 1; bus.load_sel = 0; bus.load_addr = '0; bus.load_data = 8'd99;
                bus.start = 1;
            end else begin
                bus.load_en = 0; bus.start = 0;
            end
            if (!fin) @(negedge clk);
        end
    endtask

    task automatic test_reset();
        logic [RW-1:0] got;
        idle_inputs();
        clear_model();
        #1 rst = 1;
        @(negedge clk);
        total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%0b exp=0", bus.busy); end
        total++; if (bus.done !== 1'b0) begin bad++; $display("FAIL reset_done got=%0b exp=0", bus.done); end
        total++; if (bus.rd_data !== '0) begin bad++; $display("FAIL reset_rd_data got=%0d exp=0", bus.rd_data); end
        rst = 0;
        for (int e = 0; e < NN; e++) begin
            read_c(e, got);
            total++; if (got !== '0) begin bad++; $display("FAIL reset_c[%0d] got=%0d exp=0", e, got); end
        end
    endtask

    task automatic test_basic();
        logic [RW-1:0] got, exp_c;
        int bc, dc, ov;
        int tab_c [NN] = '{30, 24, 18, 84, 69, 54, 138, 114, 90};
        for (int e = 0; e < NN; e++) load(0, e, DW'(e + 1));
        for (int e = 0; e < NN; e++) load(1, e, DW'(9 - e));
        run(0, bc, dc, ov);
        total++; if (bc != RUN_CYCLES) begin bad++; $display("FAIL basic_busy_cycles got=%0d exp=%0d", bc, RUN_CYCLES); end
        total++; if (dc != 1) begin bad++; $display("FAIL basic_done_count got=%0d exp=1", dc); end
        total++; if (ov != 0) begin bad++; $display("FAIL basic_busy_done_overlap got=%0d exp=0", ov); end
        for (int e = 0; e < NN; e++) begin
            read_c(e, got);
            exp_c = sb.pop_front();
            total++; if (got !== exp_c) begin bad++; $display("FAIL basic_c[%0d] got=%0d exp=%0d", e, got, exp_c); end
            total++; if (got !== RW'(tab_c[e])) begin bad++; $display("FAIL basic_tab_c[%0d] got=%0d exp=%0d", e, got, tab_c[e]); end
        end
    endtask

    task automatic test_extreme();
        logic [RW-1:0] got, exp_c;
        int bc, dc, ov;
`ifdef MATMUL_SIGNED_EN
        for (int e = 0; e < NN; e++) begin load(0, e, 8'h80); load(1, e, 8'h80); end
        run(0, bc, dc, ov);
        total++; if (dc != 1) begin bad++; $display("FAIL neg128_done got=%0d exp=1", dc); end
        for (int e = 0; e < NN; e++) begin
            read_c(e, got);
            exp_c = sb.pop_front();
            total++; if (got !== exp_c) begin bad++; $display("FAIL neg128_c[%0d] got=%0d exp=%0d", e, got, exp_c); end
            total++; if (got !== RW'(49152)) begin bad++; $display("FAIL neg128_const[%0d] got=%0d exp=49152", e, got); end
        end
        for (int e = 0; e < NN; e++) begin
            load(0, e, (e / N == e % N) ? 8'd1 : 8'd0);
            load(1, e, DW'(-e));
        end
        run(0, bc, dc, ov);
        for (int e = 0; e < NN; e++) begin
            read_c(e, got);
            exp_c = sb.pop_front();
            total++; if (got !== exp_c) begin bad++; $display("FAIL ident_c[%0d] got=%0h exp=%0h", e, got, exp_c); end
            total++; if (got !== RW'(-e)) begin bad++; $display("FAIL ident_const[%0d] got=%0h exp=%0h", e, got, RW'(-e)); end
        end
`else
        for (int e = 0; e < NN; e++) begin load(0, e, 8'hFF); load(1, e, 8'hFF); end
        run(0, bc, dc, ov);
        total++; if (dc != 1) begin bad++; $display("FAIL max_done got=%0d exp=1", dc); end
        for (int e = 0; e < NN; e++) begin
            read_c(e, got);
            exp_c = sb.pop_front();
            total++; if (got !== exp_c) begin bad++; $display("FAIL max_c[%0d] got=%0h exp=%0h", e, got, exp_c); end
            total++; if (got !== 18'h2FA03) begin bad++; $display("FAIL max_const[%0d] got=%0h exp=2fa03", e, got); end
        end
`endif
    endtask

    task automatic test_reset_midrun();
        logic [RW-1:0] got, exp_c;
        int bc, dc, ov, seen;
        bus.rd_addr = AW'(1);
        @(negedge clk);
        bus.start = 1;
        @(negedge clk);
        bus.start = 0;
        seen = 0;
        for (int cyc = 0; cyc < 200 && seen < 10; cyc++) begin
            if (bus.busy) seen++;
            if (seen < 10) @(negedge clk);
        end
        total++; if (bus.busy !== 1'b1) begin bad++; $display("FAIL abort_pre_busy got=%0b exp=1", bus.busy); end
        total++; if (bus.rd_data === '0) begin bad++; $display("FAIL abort_pre_rd_data got=%0d exp=nonzero", bus.rd_data); end
        #2 rst = 1;
        #1;
        total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL abort_busy got=%0b exp=0", bus.busy); end
        total++; if (bus.done !== 1'b0) begin bad++; $display("FAIL abort_done got=%0b exp=0", bus.done); end
        total++; if (bus.rd_data !== '0) begin bad++; $display("FAIL abort_rd_data got=%0d exp=0", bus.rd_data); end
        sb.delete();
        clear_model();
        @(negedge clk);
        rst = 0;
        for (int e = 0; e < NN; e++) begin
            read_c(e, got);
            total++; if (got !== '0) begin bad++; $display("FAIL abort_c[%0d] got=%0d exp=0", e, got); end
        end
        for (int e = 0; e < NN; e++) begin
            load(0, e, DW'($urandom_range(0, 255)));
            load(1, e, DW'($urandom_range(0, 255)));
        end
        run(0, bc, dc, ov);
        total++; if (bc != RUN_CYCLES) begin bad++; $display("FAIL after_abort_busy got=%0d exp=%0d", bc, RUN_CYCLES); end
        total++; if (dc != 1) begin bad++; $display("FAIL after_abort_done got=%0d exp=1", dc); end
        for (int e = 0; e < NN; e++) begin
            read_c(e, got);
            exp_c = sb.pop_front();
            total++; if (got !== exp_c) begin bad++; $display("FAIL after_abort_c[%0d] got=%0d exp=%0d", e, got, exp_c); end
        end
    endtask

    task automatic test_ignore_midrun();
        logic [RW-1:0] got, exp_c;
        int bc, dc, ov, extra;
        load(0, 0, 8'd3);
        for (int e = 0; e < NN; e++) load(1, e, DW'(e + 2));
        run(1, bc, dc, ov);
        extra = 0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            if (bus.done) extra++;
        end
        total++; if (bc != RUN_CYCLES) begin bad++; $display("FAIL inject_busy got=%0d exp=%0d", bc, RUN_CYCLES); end
        total++; if (dc + extra != 1) begin bad++; $display("FAIL inject_done_count got=%0d exp=1", dc + extra); end
        for (int e = 0; e < NN; e++) begin
            read_c(e, got);
            exp_c = sb.pop_front();
            total++; if (got !== exp_c) begin bad++; $display("FAIL inject_c[%0d] got=%0d exp=%0d", e, got, exp_c); end
        end
        load(0, 9, 8'h55);
        load(1, 9, 8'hAA);
        run(0, bc, dc, ov);
        for (int e = 0; e < NN; e++) begin
            read_c(e, got);
            exp_c = sb.pop_front();
            total++; if (got !== exp_c) begin bad++; $display("FAIL oob_load_c[%0d] got=%0d exp=%0d", e, got, exp_c); end
        end
        read_c(12, got);
        total++; if (got !== '0) begin bad++; $display("FAIL oob_read got=%0d exp=0", got); end
    endtask

    task automatic test_back_to_back();
        logic [RW-1:0] got, exp_c;
        int bc, dc, ov;
        run(0, bc, dc, ov);
        // First run's C is overwritten by the second before readback.
        for (int e = 0; e < NN; e++) void'(sb.pop_front());
        @(negedge clk);
        bus.load_en = 1; bus.load_sel = 0; bus.load_addr = AW'(4); bus.load_data = 8'd77;
        ma[4] = 8'd77;
        run(0, bc, dc, ov);
        total++; if (bc != RUN_CYCLES) begin bad++; $display("FAIL b2b_busy got=%0d exp=%0d", bc, RUN_CYCLES); end
        total++; if (dc != 1) begin bad++; $display("FAIL b2b_done got=%0d exp=1", dc); end
        for (int e = 0; e < NN; e++) begin
            read_c(e, got);
            exp_c = sb.pop_front();
            total++; if (got !== exp_c) begin bad++; $display("FAIL b2b_c[%0d] got=%0d exp=%0d", e, got, exp_c); end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog time limit reached");
        $display("test done: total=%0d bad=%0d", total, bad + 1);
        $fatal(1);
    end

    initial begin
        test_reset();
        test_basic();
        test_extreme();
        test_reset_midrun();
        test_ignore_midrun();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
